// File: rtl/kb_event_decoder_if.sv
// Byte-in / event-out bundle between the PS/2 receiver, the decoder and its reader.
// The master side drives the received bytes and the pop/clear strobes.
// The slave side (the decoder) returns the FIFO head and the status flags.
interface kb_event_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       rd_key;
  logic       clr_ovf;
  logic [9:0] key_event;
  logic       key_empty;
  logic       key_full;
  logic       overflow;
  logic       held_valid;

  modport master (
    output rx_data, rx_done_tick, rd_key, clr_ovf,
    input  key_event, key_empty, key_full, overflow, held_valid
  );

  modport slave (
    input  rx_data, rx_done_tick, rd_key, clr_ovf,
    output key_event, key_empty, key_full, overflow, held_valid
  );
endinterface

// File: rtl/kb_event_decoder.sv
// Decodes PS/2 scan-code sequences (E0/F0 prefixes) into {ext,brk,code} events queued in a FWFT FIFO.
// Latency: event written on the edge sampling the final byte; visible at key_event the next cycle.
// Backpressure: none toward the receiver; an event arriving with the FIFO full is dropped and flagged.
module kb_event_decoder #(
  parameter int unsigned W_SIZE        = 2,
  parameter bit          REPORT_MAKE   = 1'b1,
  parameter bit          REPORT_BRK    = 1'b1,
  parameter bit          FILTER_REPEAT = 1'b1
) (
  input logic               clk,
  input logic               reset,
  kb_event_decoder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << W_SIZE;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_E0     = 2'd1;
  localparam logic [1:0] S_F0     = 2'd2;
  localparam logic [1:0] S_E0F0   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        evt_vld;
  logic        evt_ext;
  logic        evt_brk;
  logic [7:0]  evt_code;
  logic [8:0]  evt_key;

  logic [8:0]  held_q, held_d;
  logic        held_valid_q, held_valid_d;
  logic        suppress;
  logic        rpt_en;
  logic        wr_req;

  logic [9:0]  mem_q [DEPTH];
  logic [W_SIZE:0] wr_ptr_q, wr_ptr_d;
  logic [W_SIZE:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_empty;
  logic        fifo_full;
  logic        rd_en;
  logic        wr_en;
  logic        drop;
  logic        overflow_q, overflow_d;

  // Prefix tracking: both prefixes may arrive in either order and repeat freely.
  always_comb begin
    state_d  = state_q;
    evt_vld  = 1'b0;
    evt_ext  = 1'b0;
    evt_brk  = 1'b0;
    evt_code = bus.rx_data;
    if (bus.rx_done_tick) begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_data == B_E0)      state_d = S_E0;
          else if (bus.rx_data == B_F0) state_d = S_F0;
          else                          evt_vld = 1'b1;
        end
        S_E0: begin
          if (bus.rx_data == B_F0)      state_d = S_E0F0;
          else if (bus.rx_data != B_E0) begin
            evt_vld = 1'b1;
            evt_ext = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_F0: begin
          if (bus.rx_data == B_E0)      state_d = S_E0F0;
          else if (bus.rx_data != B_F0) begin
            evt_vld = 1'b1;
            evt_brk = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          if (bus.rx_data != B_E0 && bus.rx_data != B_F0) begin
            evt_vld = 1'b1;
            evt_ext = 1'b1;
            evt_brk = 1'b1;
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  // Decoder state register; reset throws away any half-received prefix.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign evt_key  = {evt_ext, evt_code};
  assign suppress = FILTER_REPEAT && !evt_brk && held_valid_q && (held_q == evt_key);
  assign rpt_en   = evt_brk ? REPORT_BRK : REPORT_MAKE;
  assign wr_req   = evt_vld && !suppress && rpt_en;

  // Held-key tracking runs even when the event class is not being reported.
  always_comb begin
    held_d       = held_q;
    held_valid_d = held_valid_q;
    if (evt_vld) begin
      if (!evt_brk && !suppress) begin
        held_d       = evt_key;
        held_valid_d = 1'b1;
      end else if (evt_brk && held_q == evt_key) begin
        held_valid_d = 1'b0;
      end
    end
  end

  // Held-key registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_q       <= '0;
      held_valid_q <= 1'b0;
    end else begin
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[W_SIZE] != rd_ptr_q[W_SIZE]) &&
                      (wr_ptr_q[W_SIZE-1:0] == rd_ptr_q[W_SIZE-1:0]);
  assign rd_en      = bus.rd_key && !fifo_empty;
  // A same-cycle pop makes room, so a full FIFO only drops when nothing is read.
  assign wr_en      = wr_req && (!fifo_full || rd_en);
  assign drop       = wr_req && fifo_full && !rd_en;

  // Next pointer and sticky overflow values; a drop beats a clear in the same cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop)             overflow_d = 1'b1;
    else if (bus.clr_ovf) overflow_d = 1'b0;
  end

  // FIFO pointers and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[W_SIZE-1:0]] <= {evt_ext, evt_brk, evt_code};
  end

  assign bus.key_event  = fifo_empty ? 10'd0 : mem_q[rd_ptr_q[W_SIZE-1:0]];
  assign bus.key_empty  = fifo_empty;
  assign bus.key_full   = fifo_full;
  assign bus.overflow   = overflow_q;
  assign bus.held_valid = held_valid_q;

endmodule

// File: tb/tb_kb_event_decoder.sv
// Bench for kb_event_decoder: three parameter variants share one directed byte stream.
// A queue-style model predicts every output each cycle; literal checks pin key moments.
module tb_kb_event_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic       rd_key = 1'b0;
  logic       clr_ovf = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  kb_event_decoder_if ifa ();
  kb_event_decoder_if ifb ();
  kb_event_decoder_if ifc ();

  assign ifa.rx_data = rx_data;  assign ifa.rx_done_tick = rx_done_tick;
  assign ifa.rd_key  = rd_key;   assign ifa.clr_ovf      = clr_ovf;
  assign ifb.rx_data = rx_data;  assign ifb.rx_done_tick = rx_done_tick;
  assign ifb.rd_key  = rd_key;   assign ifb.clr_ovf      = clr_ovf;
  assign ifc.rx_data = rx_data;  assign ifc.rx_done_tick = rx_done_tick;
  assign ifc.rd_key  = rd_key;   assign ifc.clr_ovf      = clr_ovf;

  // a: defaults; b: no repeat filter; c: breaks not reported
  kb_event_decoder #(.W_SIZE(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  kb_event_decoder #(.W_SIZE(2), .FILTER_REPEAT(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  kb_event_decoder #(.W_SIZE(2), .REPORT_BRK(1'b0)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  localparam bit [2:0] P_FR = 3'b101;
  localparam bit [2:0] P_RM = 3'b111;
  localparam bit [2:0] P_RB = 3'b011;
  localparam int       MDEPTH = 4;

  // ---------------- behavioural model ----------------
  bit         minit = 1'b0;
  bit         pfx_ext, pfx_brk;
  logic [9:0] mbuf [3][8];
  int         mcnt [3];
  bit         movf [3];
  bit         mhv  [3];
  logic [8:0] mheld [3];

  always @(posedge clk) begin
    bit         ev_v;
    logic [9:0] ev;
    logic [8:0] key;
    bit         wr, pop, sup;
    if (reset) begin
      minit   = 1'b1;
      pfx_ext = 1'b0;
      pfx_brk = 1'b0;
      for (int i = 0; i < 3; i++) begin
        mcnt[i] = 0; movf[i] = 1'b0; mhv[i] = 1'b0; mheld[i] = '0;
      end
    end else begin
      ev_v = 1'b0;
      ev   = '0;
      if (rx_done_tick) begin
        if (rx_data == 8'hE0)      pfx_ext = 1'b1;
        else if (rx_data == 8'hF0) pfx_brk = 1'b1;
        else begin
          ev_v = 1'b1;
          ev   = {pfx_ext, pfx_brk, rx_data};
          pfx_ext = 1'b0;
          pfx_brk = 1'b0;
        end
      end
      for (int i = 0; i < 3; i++) begin
        wr  = 1'b0;
        pop = rd_key && (mcnt[i] > 0);
        if (ev_v) begin
          key = {ev[9], ev[7:0]};
          if (!ev[8]) begin
            sup = P_FR[i] && mhv[i] && (mheld[i] == key);
            if (!sup) begin mheld[i] = key; mhv[i] = 1'b1; end
            wr = !sup && P_RM[i];
          end else begin
            if (mheld[i] == key) mhv[i] = 1'b0;
            wr = P_RB[i];
          end
        end
        if (pop) begin
          for (int k = 0; k < 7; k++) mbuf[i][k] = mbuf[i][k+1];
          mcnt[i]--;
        end
        if (wr && mcnt[i] < MDEPTH) begin
          mbuf[i][mcnt[i]] = ev;
          mcnt[i]++;
        end else if (wr) begin
          movf[i] = 1'b1;
        end else if (clr_ovf) begin
          movf[i] = 1'b0;
        end
        if (wr && mcnt[i] <= MDEPTH && clr_ovf && !(movf[i] && mcnt[i] == MDEPTH && !pop)) begin
          // a successful write does not block a clear
          movf[i] = movf[i] && (mcnt[i] == MDEPTH) && !pop && wr ? movf[i] : 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic [9:0] ev, input logic e, input logic f,
                     input logic o, input logic h);
    logic [9:0] exp_ev;
    exp_ev = (mcnt[i] > 0) ? mbuf[i][0] : 10'd0;
    chk($sformatf("u%0d.key_event", i), ev, exp_ev);
    chk($sformatf("u%0d.key_empty", i), {9'd0, e}, {9'd0, mcnt[i] == 0});
    chk($sformatf("u%0d.key_full", i), {9'd0, f}, {9'd0, mcnt[i] == MDEPTH});
    chk($sformatf("u%0d.overflow", i), {9'd0, o}, {9'd0, movf[i]});
    chk($sformatf("u%0d.held_valid", i), {9'd0, h}, {9'd0, mhv[i]});
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (minit) begin
      cmp(0, ifa.key_event, ifa.key_empty, ifa.key_full, ifa.overflow, ifa.held_valid);
      cmp(1, ifb.key_event, ifb.key_empty, ifb.key_full, ifb.overflow, ifb.held_valid);
      cmp(2, ifc.key_event, ifc.key_empty, ifc.key_full, ifc.overflow, ifc.held_valid);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic pop_one();
    rd_key = 1'b1;
    @(posedge clk); #1;
    rd_key = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    chk("rst.key_empty", {9'd0, ifa.key_empty}, 10'd1);
    chk("rst.key_full", {9'd0, ifa.key_full}, 10'd0);
    chk("rst.overflow", {9'd0, ifa.overflow}, 10'd0);
    chk("rst.held_valid", {9'd0, ifa.held_valid}, 10'd0);
    chk("rst.key_event", ifa.key_event, 10'h000);

    // make then break of 1C, back to back ticks
    tick_byte(8'h1C);
    chk("s1.first_empty", {9'd0, ifa.key_empty}, 10'd0);
    chk("s1.first_event", ifa.key_event, 10'h01C);
    tick_byte(8'hF0);
    tick_byte(8'h1C);
    idle(1);
    pop_one();
    chk("s1.second_event", ifa.key_event, 10'h11C);
    chk("s1.c_brk_dropped", {9'd0, ifc.key_empty}, 10'd1);
    pop_one();
    chk("s1.drained", {9'd0, ifa.key_empty}, 10'd1);

    // extended make/break
    tick_byte(8'hE0);
    tick_byte(8'h75);
    chk("s2.held_rise", {9'd0, ifa.held_valid}, 10'd1);
    chk("s2.ext_make", ifa.key_event, 10'h275);
    tick_byte(8'hE0);
    tick_byte(8'hF0);
    tick_byte(8'h75);
    chk("s2.held_fall", {9'd0, ifa.held_valid}, 10'd0);
    pop_one();
    chk("s2.ext_break", ifa.key_event, 10'h375);
    pop_one();

    // typematic repeat
    tick_byte(8'h1C); idle(1);
    tick_byte(8'h1C); idle(1);
    tick_byte(8'h1C); idle(1);
    tick_byte(8'hF0);
    tick_byte(8'h1C);
    chk("s3.nofilter_full", {9'd0, ifb.key_full}, 10'd1);
    chk("s3.filter_head", ifa.key_event, 10'h01C);
    pop_one();
    chk("s3.filter_second", ifa.key_event, 10'h11C);
    chk("s3.nofilter_second", ifb.key_event, 10'h01C);
    pop_one(); pop_one(); pop_one();
    chk("s3.nofilter_drained", {9'd0, ifb.key_empty}, 10'd1);

    // fill and overflow
    tick_byte(8'h15);
    tick_byte(8'h1D);
    tick_byte(8'h24);
    tick_byte(8'h2D);
    chk("s4.full", {9'd0, ifa.key_full}, 10'd1);
    chk("s4.no_ovf_yet", {9'd0, ifa.overflow}, 10'd0);
    tick_byte(8'h2C);
    chk("s4.ovf_set", {9'd0, ifa.overflow}, 10'd1);
    chk("s4.head_kept", ifa.key_event, 10'h015);
    clr_ovf = 1'b1; idle(1); clr_ovf = 1'b0;
    chk("s4.ovf_clr", {9'd0, ifa.overflow}, 10'd0);

    // pop and push together while full
    rd_key = 1'b1;
    tick_byte(8'h35);
    rd_key = 1'b0;
    chk("s5.no_ovf", {9'd0, ifa.overflow}, 10'd0);
    chk("s5.still_full", {9'd0, ifa.key_full}, 10'd1);
    chk("s5.head_adv", ifa.key_event, 10'h01D);
    pop_one(); chk("s5.seq024", ifa.key_event, 10'h024);
    pop_one(); chk("s5.seq02D", ifa.key_event, 10'h02D);
    pop_one(); chk("s5.tail035", ifa.key_event, 10'h035);
    pop_one();

    // pop while empty plus a new byte: write only
    rd_key = 1'b1;
    tick_byte(8'h5A);
    rd_key = 1'b0;
    chk("s6.rw_empty", ifa.key_event, 10'h05A);
    pop_one();
    idle(1);
    chk("s6.rd_empty_ignored", {9'd0, ifa.key_empty}, 10'd1);

    // reset mid-sequence discards the prefix
    tick_byte(8'hE0);
    tick_byte(8'hF0);
    reset = 1'b1; idle(1); reset = 1'b0;
    tick_byte(8'h1C);
    chk("s7.prefix_gone", ifa.key_event, 10'h01C);
    tick_byte(8'hF0);
    tick_byte(8'h1C);
    chk("s7.c_held_clr", {9'd0, ifc.held_valid}, 10'd0);
    chk("s7.c_only_make", ifc.key_event, 10'h01C);
    pop_one();
    chk("s7.c_empty", {9'd0, ifc.key_empty}, 10'd1);
    pop_one();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
